// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with wrap/saturate overflow handling, variable step,
// enable prescaler, registered terminal-count pulse and sticky overflow flag.
module param_up_down_counter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MAX_VALUE  = 2**WIDTH - 1,
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  sat_mode,
   input  logic [WIDTH-1:0]      step,
   input  logic [PRESCALE_W-1:0] div,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  ovf,
   output logic                  at_max,
   output logic                  at_min
);

   localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH:0]   ModV = (WIDTH+1)'(MAX_VALUE + 1);

   logic [WIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic                  tc_q, tc_d;
   logic                  ovf_q, ovf_d;

   logic [WIDTH-1:0] step_c;
   logic [WIDTH:0]   sum;
   logic             tick;
   logic             event_hit;

   always_comb begin
      step_c    = (step > MaxV) ? MaxV : step;
      sum       = {1'b0, count_q} + {1'b0, step_c};
      tick      = en && (pcnt_q == div);
      event_hit = 1'b0;
      count_d   = count_q;
      pcnt_d    = pcnt_q;
      tc_d      = 1'b0;
      ovf_d     = ovf_q;

      if (load) begin
         count_d = (load_value > MaxV) ? MaxV : load_value;
         pcnt_d  = '0;
         ovf_d   = 1'b0;
      end else if (en) begin
         // pcnt above div simply runs through the natural wrap; no early tick
         pcnt_d = tick ? '0 : pcnt_q + 1'b1;
         if (tick) begin
            if (up) begin
               if (sum <= {1'b0, MaxV}) begin
                  count_d = sum[WIDTH-1:0];
               end else begin
                  event_hit = 1'b1;
                  count_d   = sat_mode ? MaxV : WIDTH'(sum - ModV);
               end
            end else begin
               if (step_c <= count_q) begin
                  count_d = count_q - step_c;
               end else begin
                  event_hit = 1'b1;
                  count_d   = sat_mode ? '0 : WIDTH'({1'b0, count_q} + ModV - {1'b0, step_c});
               end
            end
         end
         tc_d  = event_hit;
         ovf_d = ovf_q | event_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         pcnt_q  <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         pcnt_q  <= pcnt_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count  = count_q;
   assign tc     = tc_q;
   assign ovf    = ovf_q;
   assign at_max = (count_q == MaxV);
   assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Scoreboard bench for param_up_down_counter configured as a decade counter (WIDTH=4, MAX=9).
module tb_param_up_down_counter;

   localparam int W    = 4;
   localparam int MAXV = 9;
   localparam int PW   = 4;

   logic          clk = 1'b0;
   logic          rst_n, en, up, sat_mode, load;
   logic [W-1:0]  step, load_value;
   logic [PW-1:0] div;
   logic [W-1:0]  count;
   logic          tc, ovf, at_max, at_min;

   always #5 clk = ~clk;

   param_up_down_counter #(
      .WIDTH      (W),
      .MAX_VALUE  (MAXV),
      .PRESCALE_W (PW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .up         (up),
      .sat_mode   (sat_mode),
      .step       (step),
      .div        (div),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .tc         (tc),
      .ovf        (ovf),
      .at_max     (at_max),
      .at_min     (at_min)
   );

   typedef struct packed {
      logic [W-1:0] count;
      logic         tc;
      logic         ovf;
      logic         at_max;
      logic         at_min;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state
   int m_count = 0;
   int m_pcnt  = 0;
   bit m_tc    = 1'b0;
   bit m_ovf   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model with the inputs currently driven and queue the expected outputs.
   task automatic model_step();
      int   sc, s;
      bit   ev;
      exp_t e;
      ev = 1'b0;
      if (!rst_n) begin
         m_count = 0; m_pcnt = 0; m_tc = 0; m_ovf = 0;
      end else if (load) begin
         m_count = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
         m_pcnt  = 0; m_ovf = 0; m_tc = 0;
      end else begin
         if (en) begin
            if (m_pcnt == int'(div)) begin
               m_pcnt = 0;
               sc = (int'(step) > MAXV) ? MAXV : int'(step);
               if (up) begin
                  s = m_count + sc;
                  if (s > MAXV) begin
                     ev = 1'b1;
                     m_count = sat_mode ? MAXV : s - (MAXV + 1);
                  end else m_count = s;
               end else begin
                  s = m_count - sc;
                  if (s < 0) begin
                     ev = 1'b1;
                     m_count = sat_mode ? 0 : s + MAXV + 1;
                  end else m_count = s;
               end
            end else begin
               m_pcnt = (m_pcnt + 1) % (1 << PW);
            end
         end
         m_tc = ev;
         if (ev) m_ovf = 1'b1;
      end
      e.count  = W'(m_count);
      e.tc     = m_tc;
      e.ovf    = m_ovf;
      e.at_max = (m_count == MAXV);
      e.at_min = (m_count == 0);
      sb_q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("count",  count,  e.count);
      check_val("tc",     tc,     e.tc);
      check_val("ovf",    ovf,    e.ovf);
      check_val("at_max", at_max, e.at_max);
      check_val("at_min", at_min, e.at_min);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_load(input int v);
      load = 1'b1; load_value = W'(v);
      cycle();
      load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; up = 1'b1; sat_mode = 1'b0; load = 1'b0;
      step = 4'd1; load_value = '0; div = '0;

      // Reset held for two edges
      cycles(2);
      check_val("rst_count", count, 0);
      check_val("rst_min",   at_min, 1);
      rst_n = 1'b1;
      cycle();
      check_val("first_inc", count, 1);

      // Decade wrap
      do_load(7);
      check_val("load7", count, 7);
      cycle(); check_val("wrap8", count, 8);
      cycle(); check_val("wrap9", count, 9); check_val("wrap9_max", at_max, 1);
      check_val("wrap9_tc", tc, 0);
      cycle(); check_val("wrap0", count, 0); check_val("wrap0_tc", tc, 1);
      check_val("wrap0_ovf", ovf, 1);
      cycle(); check_val("wrap1", count, 1); check_val("wrap1_tc", tc, 0);
      check_val("wrap1_ovf", ovf, 1);

      // Saturate down
      do_load(2);
      sat_mode = 1'b1; up = 1'b0; step = 4'd3;
      cycle(); check_val("sat0", count, 0); check_val("sat0_tc", tc, 1);
      cycle(); check_val("sat0b", count, 0); check_val("sat0b_tc", tc, 1);
      check_val("sat_ovf", ovf, 1);
      // Wrap rerun
      do_load(2);
      sat_mode = 1'b0;
      cycle(); check_val("wrapdn9", count, 9); check_val("wrapdn_tc", tc, 1);
      cycle(); check_val("wrapdn6", count, 6); check_val("wrapdn6_tc", tc, 0);

      // Prescaler with an enable gap mid-phase
      up = 1'b1; step = 4'd1; div = 4'd2;
      do_load(0);
      cycles(2); check_val("pre_hold", count, 0);
      cycle();   check_val("pre_e3", count, 1);
      cycle();
      en = 1'b0; cycles(5); check_val("pre_gap", count, 1);
      en = 1'b1;
      cycle();   check_val("pre_e5", count, 1);
      cycle();   check_val("pre_e6", count, 2);

      // Load priority and clamping on a tick cycle with ovf set
      div = 4'd0; load = 1'b0; do_load(9);
      cycle(); check_val("pre_ovf", ovf, 1);
      load = 1'b1; load_value = 4'd12; en = 1'b1;
      cycle(); load = 1'b0;
      check_val("clamp", count, 9); check_val("clamp_ovf", ovf, 0);
      check_val("clamp_tc", tc, 0);
      // Oversized step behaves as MAX_VALUE
      do_load(0);
      step = 4'd15;
      cycle(); check_val("bigstep", count, 9); check_val("bigstep_tc", tc, 0);

      // Reset mid-operation with ovf set and prescaler mid-phase
      step = 4'd3; do_load(8);
      cycle(); check_val("mid_wrap", count, 1);
      step = 4'd4;
      cycle(); check_val("mid5", count, 5); check_val("mid5_ovf", ovf, 1);
      div = 4'd3; cycles(2);
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      check_val("mid_rst", count, 0); check_val("mid_rst_ovf", ovf, 0);
      step = 4'd1;
      cycles(3); check_val("mid_phase", count, 0);
      cycle();   check_val("mid_tick", count, 1);

      // Glitch on rst_n between edges
      div = 4'd0;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      cycle(); check_val("glitch", count, 2);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst_n      = ($urandom_range(0, 40) != 0);
         load       = ($urandom_range(0, 9) == 0);
         en         = ($urandom_range(0, 3) != 0);
         up         = 1'($urandom_range(0, 1));
         sat_mode   = 1'($urandom_range(0, 1));
         step       = W'($urandom_range(0, 15));
         load_value = W'($urandom_range(0, 15));
         div        = PW'($urandom_range(0, 3));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
